// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory port between the processor load/store
// path (port 0) and a secondary requester (port 1). Round-robin arbitration,
// combinational grants, registered read data.
// Optional feature macro: ARB_BURST_LOCK_EN builds burst locking
// (OWN0/OWN1 ownership states, lock_cnt timeout and lock_err).
//
// state | meaning
// ARB   | unlocked, round-robin between requesters
// OWN0  | port 0 holds the memory for a burst
// OWN1  | port 1 holds the memory for a burst
module dmem_arbiter #(
  parameter int DBITS        = 32,
  parameter int ADDR_BITS    = 30,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [DBITS-1:0]     wdata0,
  input  logic                 lock0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [DBITS-1:0]     wdata1,
  input  logic                 lock1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DBITS-1:0]     rdata,
  output logic                 lock_err,
  output logic                 mem_en_write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DBITS-1:0]     mem_din,
  input  logic [DBITS-1:0]     mem_dout
);

  // last = port granted most recently; the other port wins the next contention
  logic last;
  logic rvalid0_q;
  logic rvalid1_q;
  logic arb_gnt0;
  logic arb_gnt1;

  assign arb_gnt0 = req0 & (~req1 | last);
  assign arb_gnt1 = req1 & (~req0 | ~last);

`ifdef ARB_BURST_LOCK_EN
  typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;

  localparam int CNT_BITS = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_BITS-1:0] CNT_TC = CNT_BITS'(LOCK_TIMEOUT - 1);

  state_t              state;
  logic [CNT_BITS-1:0] lock_cnt;
  logic                lock_err_q;

  // Grant selection: the owning port is the only candidate while locked
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state)
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: begin
          gnt0 = arb_gnt0;
          gnt1 = arb_gnt1;
        end
      endcase
    end
  end

  // Lock ownership FSM with forced release after LOCK_TIMEOUT cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      lock_cnt   <= '0;
      lock_err_q <= 1'b0;
    end else begin
      lock_err_q <= 1'b0;
      case (state)
        ARB: begin
          if (gnt0 && lock0) begin
            state    <= OWN0;
            lock_cnt <= '0;
          end else if (gnt1 && lock1) begin
            state    <= OWN1;
            lock_cnt <= '0;
          end
        end
        OWN0: begin
          if (lock_cnt == CNT_TC) begin
            state      <= ARB;
            lock_cnt   <= '0;
            lock_err_q <= 1'b1;
          end else if (gnt0 && !lock0) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        OWN1: begin
          if (lock_cnt == CNT_TC) begin
            state      <= ARB;
            lock_cnt   <= '0;
            lock_err_q <= 1'b1;
          end else if (gnt1 && !lock1) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ARB;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  assign lock_err = lock_err_q;
`else
  // Pure round-robin: the lock inputs and timeout have no effect in this build
  logic unused_lock;
  localparam int unused_timeout = LOCK_TIMEOUT;
  assign unused_lock = lock0 ^ lock1;

  // Grant selection, round-robin only
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt0 = arb_gnt0;
      gnt1 = arb_gnt1;
    end
  end

  assign lock_err = 1'b0;
`endif

  // Memory mux: port 1 only when granted, otherwise port 0 values pass through
  always_comb begin
    mem_addr     = gnt1 ? addr1 : addr0;
    mem_din      = gnt1 ? wdata1 : wdata0;
    mem_en_write = (gnt0 & we0) | (gnt1 & we1);
  end

  // Round-robin pointer, read data capture and read-valid pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata     <= '0;
    end else begin
      if (gnt0) begin
        last <= 1'b0;
      end else if (gnt1) begin
        last <= 1'b1;
      end
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if ((gnt0 & ~we0) | (gnt1 & ~we1)) begin
        rdata <= mem_dout;
      end
    end
  end

  // A response still in flight when reset arrives is not reported
  assign rvalid0 = rvalid0_q & ~reset;
  assign rvalid1 = rvalid1_q & ~reset;

endmodule
